// File: rtl/itf_reg_master.sv
// Host-command to ITF indirect-register master: turns one 16-bit register
// read/write into byte-wide accesses on the itf2reg slave window.
module itf_reg_master #(
  parameter int RD_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [7:0]  itf_addr,
  output logic [7:0]  itf_wdata,
  output logic        itf_wr,
  input  logic [7:0]  itf_rdata
);

  localparam logic [7:0] A_OPERATION = 8'h01;
  localparam logic [7:0] A_ADDR_0B   = 8'h02;
  localparam logic [7:0] A_WDATA_0B  = 8'h03;
  localparam logic [7:0] A_WDATA_1B  = 8'h04;
  localparam logic [7:0] A_RDATA_0B  = 8'h05;
  localparam logic [7:0] A_RDATA_1B  = 8'h06;
  localparam logic [7:0] OP_WRITE    = 8'h03;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [3:0] WAIT_INIT   = 4'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_D0, W_D1, W_OP, R_OP, R_WAIT, R_B0, R_B1, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  itf_addr_q, itf_addr_d;
  logic [7:0]  itf_wdata_q, itf_wdata_d;
  logic        itf_wr_q, itf_wr_d;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign itf_addr  = itf_addr_q;
  assign itf_wdata = itf_wdata_q;
  assign itf_wr    = itf_wr_q;

  // Next-state, command latch, read capture and the registered ITF outputs
  // (the latter decoded from the next state so they line up with it).
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = W_ADDR;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      W_ADDR: state_d = we_q ? W_D0 : R_OP;
      W_D0:   state_d = W_D1;
      W_D1:   state_d = W_OP;
      W_OP:   state_d = DONE;
      R_OP: begin
        if (RD_WAIT == 0) begin
          state_d = R_B0;
        end else begin
          state_d = R_WAIT;
          wcnt_d  = WAIT_INIT;
        end
      end
      R_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = R_B0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      R_B0: begin
        rdata_d[7:0] = itf_rdata;
        state_d      = R_B1;
      end
      R_B1: begin
        rdata_d[15:8] = itf_rdata;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    itf_addr_d  = 8'h00;
    itf_wdata_d = 8'h00;
    itf_wr_d    = 1'b0;
    case (state_d)
      W_ADDR: begin itf_addr_d = A_ADDR_0B;   itf_wdata_d = addr_d;         itf_wr_d = 1'b1; end
      W_D0:   begin itf_addr_d = A_WDATA_0B;  itf_wdata_d = wdata_d[7:0];   itf_wr_d = 1'b1; end
      W_D1:   begin itf_addr_d = A_WDATA_1B;  itf_wdata_d = wdata_d[15:8];  itf_wr_d = 1'b1; end
      W_OP:   begin itf_addr_d = A_OPERATION; itf_wdata_d = OP_WRITE;       itf_wr_d = 1'b1; end
      R_OP:   begin itf_addr_d = A_OPERATION; itf_wdata_d = OP_READ;        itf_wr_d = 1'b1; end
      R_WAIT: itf_addr_d = A_RDATA_0B;
      R_B0:   itf_addr_d = A_RDATA_0B;
      R_B1:   itf_addr_d = A_RDATA_1B;
      default: begin
        itf_addr_d  = 8'h00;
        itf_wdata_d = 8'h00;
        itf_wr_d    = 1'b0;
      end
    endcase
    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 16'h0000;
      rdata_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      itf_addr_q  <= 8'h00;
      itf_wdata_q <= 8'h00;
      itf_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      itf_addr_q  <= itf_addr_d;
      itf_wdata_q <= itf_wdata_d;
      itf_wr_q    <= itf_wr_d;
    end
  end

endmodule
